// File: rtl/axis_pkt_fifo_pkg.sv
// Shared definitions for the store-and-forward AXI-Stream packet FIFO.
package axis_pkt_fifo_pkg;

    // One extra pointer bit separates full from empty.
    localparam int PTR_EXTRA_BITS = 1;

    typedef enum logic {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } wr_state_e;

    function automatic int ptr_width(input int depth_log2);
        return depth_log2 + PTR_EXTRA_BITS;
    endfunction

    // RAM word is {tlast, tdata}.
    function automatic int tlast_bit(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_ram.sv
// Simple dual-port packet RAM, one write port and one registered read port.
module axis_pkt_fifo_ram #(
    parameter int WORD_W = 65,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/axistream_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: never back-pressures, drops whole
// packets on overflow, and only exposes packets whose last beat is stored.
module axistream_pkt_fifo
    import axis_pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH_LOG2 = 9,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  axi_aclk,
    input  logic                  axi_areset,
    input  logic [DATA_WIDTH-1:0] in_TDATA,
    input  logic                  in_TVALID,
    input  logic                  in_TLAST,
    output logic                  in_TREADY,
    output logic [DATA_WIDTH-1:0] out_TDATA,
    output logic                  out_TVALID,
    output logic                  out_TLAST,
    input  logic                  out_TREADY,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic [DEPTH_LOG2:0]   pkt_count
);

    localparam int PW = ptr_width(DEPTH_LOG2);
    localparam int TL = tlast_bit(DATA_WIDTH);
    localparam int WW = DATA_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = {1'b1, {DEPTH_LOG2{1'b0}}};

    wr_state_e       state;
    logic [PW-1:0]   wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
    logic            beat, full, wr_en, commit, pop, last_pop, fetch;
    logic            rd_vld, skid_vld;
    logic [WW-1:0]   rd_data, skid_data;
    logic [2:0]      occ;

    // rd_ptr only advances on downstream handshake, so beats held in the
    // output pipeline still count against capacity.
    assign beat     = in_TVALID && in_TREADY;
    assign full     = (wr_ptr - rd_ptr) == DEPTH_P;
    assign wr_en    = beat && (state == ACCEPT) && !full;
    assign commit   = wr_en && in_TLAST;
    assign pop      = out_TVALID && out_TREADY;
    assign last_pop = pop && out_TLAST;

    // Prefetch only if the beat can land without overrunning the 2-entry buffer.
    always_comb begin
        occ   = 3'(out_TVALID) + 3'(skid_vld) + 3'(rd_vld) - 3'(pop);
        fetch = (fetch_ptr != commit_ptr) && (occ <= 3'd1);
    end

    axis_pkt_fifo_ram #(
        .WORD_W (WW),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (axi_aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
        .wr_data ({in_TLAST, in_TDATA}),
        .rd_en   (fetch),
        .rd_addr (fetch_ptr[DEPTH_LOG2-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            in_TREADY  <= 1'b0;
            state      <= ACCEPT;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            drop_count <= '0;
        end else begin
            in_TREADY <= 1'b1;
            if (beat) begin
                case (state)
                    ACCEPT: begin
                        if (!full) begin
                            wr_ptr <= wr_ptr + PW'(1);
                            if (in_TLAST)
                                commit_ptr <= wr_ptr + PW'(1);
                        end else begin
                            wr_ptr <= commit_ptr;
                            if (drop_count != '1)
                                drop_count <= drop_count + CNT_WIDTH'(1);
                            if (!in_TLAST)
                                state <= DROP;
                        end
                    end
                    DROP: begin
                        if (in_TLAST)
                            state <= ACCEPT;
                    end
                    default: state <= ACCEPT;
                endcase
            end
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            fetch_ptr  <= '0;
            rd_ptr     <= '0;
            rd_vld     <= 1'b0;
            skid_vld   <= 1'b0;
            skid_data  <= '0;
            out_TVALID <= 1'b0;
            out_TLAST  <= 1'b0;
            out_TDATA  <= '0;
            pkt_count  <= '0;
        end else begin
            rd_vld <= fetch;
            if (fetch)
                fetch_ptr <= fetch_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);

            if (!out_TVALID || pop) begin
                if (skid_vld) begin
                    {out_TLAST, out_TDATA} <= skid_data;
                    out_TVALID             <= 1'b1;
                    skid_vld               <= rd_vld;
                    if (rd_vld)
                        skid_data <= rd_data;
                end else if (rd_vld) begin
                    out_TLAST  <= rd_data[TL];
                    out_TDATA  <= rd_data[TL-1:0];
                    out_TVALID <= 1'b1;
                end else begin
                    out_TVALID <= 1'b0;
                end
            end else if (rd_vld) begin
                skid_vld  <= 1'b1;
                skid_data <= rd_data;
            end

            case ({commit, last_pop})
                2'b10:   pkt_count <= pkt_count + PW'(1);
                2'b01:   pkt_count <= pkt_count - PW'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

endmodule
